// File: rtl/mem_byte_sequencer_if.sv
// rtl/mem_byte_sequencer_if.sv - Request/response and byte-memory signal bundle for mem_byte_sequencer
interface mem_byte_sequencer_if;
    logic        req_valid;
    logic        req_rw;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_se;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        misaligned;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, req_size, req_se, mem_rdata,
        output req_ready, stall, rsp_valid, rsp_rdata, misaligned,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_rw, req_addr, req_wdata, req_size, req_se, mem_rdata,
        input  req_ready, stall, rsp_valid, rsp_rdata, misaligned,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_byte_sequencer.sv
// rtl/mem_byte_sequencer.sv - MEM-stage sequencer splitting loads/stores into big-endian byte memory cycles
module mem_byte_sequencer (
    input  logic                 Clk,
    input  logic                 R,
    mem_byte_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, XFER, CAPT, DONE} state_t;

    state_t      state, state_d;
    logic [1:0]  count, count_d;
    logic [31:0] acc, acc_d;
    logic [31:0] base, base_d;
    logic [31:0] wdata, wdata_d;
    logic [1:0]  size, size_d;
    logic        se, se_d;
    logic        rw, rw_d;
    logic        err, err_d;
    logic        rd_pending, rd_pending_d;

    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        req_bad;
    logic [1:0]  last_d;
    logic [1:0]  byte_sel;
    logic [31:0] ext_d;

    function automatic logic [1:0] last_index(input logic [1:0] sz);
        case (sz)
            2'b00:   last_index = 2'd0;
            2'b01:   last_index = 2'd1;
            default: last_index = 2'd3;
        endcase
    endfunction

    always_comb begin
        req_bad = 1'b0;
        case (bus.req_size)
            2'b00:   req_bad = 1'b0;
            2'b01:   req_bad = bus.req_addr[0];
            2'b10:   req_bad = (bus.req_addr[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    end

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_d = state;
        count_d = count;
        acc_d   = acc;
        base_d  = base;
        wdata_d = wdata;
        size_d  = size;
        se_d    = se;
        rw_d    = rw;
        err_d   = err;

        // Synchronous memory: read data of the previous cycle's read is valid now.
        if (rd_pending) begin
            acc_d = {acc[23:0], bus.mem_rdata};
        end

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    base_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    size_d  = bus.req_size;
                    se_d    = bus.req_se;
                    rw_d    = bus.req_rw;
                    err_d   = req_bad;
                    count_d = 2'd0;
                    acc_d   = 32'd0;
                    state_d = req_bad ? DONE : XFER;
                end
            end
            XFER: begin
                if (count == last_index(size)) begin
                    state_d = rw ? DONE : CAPT;
                end else begin
                    count_d = count + 2'd1;
                end
            end
            CAPT:    state_d = DONE;
            default: state_d = IDLE;
        endcase

        last_d   = last_index(size_d);
        byte_sel = last_d - count_d;

        mem_en_d    = (state_d == XFER);
        mem_we_d    = mem_en_d & rw_d;
        mem_addr_d  = mem_en_d ? (base_d + {30'd0, count_d}) : 32'd0;
        mem_wdata_d = 8'd0;
        if (mem_en_d) begin
            case (byte_sel)
                2'd0:    mem_wdata_d = wdata_d[7:0];
                2'd1:    mem_wdata_d = wdata_d[15:8];
                2'd2:    mem_wdata_d = wdata_d[23:16];
                default: mem_wdata_d = wdata_d[31:24];
            endcase
        end
        rd_pending_d = mem_en_q & ~mem_we_q;

        case (size_d)
            2'b00:   ext_d = {{24{se_d & acc_d[7]}}, acc_d[7:0]};
            2'b01:   ext_d = {{16{se_d & acc_d[15]}}, acc_d[15:0]};
            default: ext_d = acc_d;
        endcase

        rsp_valid_d  = (state_d == DONE);
        misaligned_d = rsp_valid_d & err_d;
        rsp_rdata_d  = (rsp_valid_d && !rw_d && !err_d) ? ext_d : 32'd0;
    end

    always_ff @(posedge Clk or posedge R) begin
        if (R) begin
            state        <= IDLE;
            count        <= 2'd0;
            acc          <= 32'd0;
            base         <= 32'd0;
            wdata        <= 32'd0;
            size         <= 2'd0;
            se           <= 1'b0;
            rw           <= 1'b0;
            err          <= 1'b0;
            rd_pending   <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 8'd0;
            rsp_valid_q  <= 1'b0;
            misaligned_q <= 1'b0;
            rsp_rdata_q  <= 32'd0;
        end else begin
            state        <= state_d;
            count        <= count_d;
            acc          <= acc_d;
            base         <= base_d;
            wdata        <= wdata_d;
            size         <= size_d;
            se           <= se_d;
            rw           <= rw_d;
            err          <= err_d;
            rd_pending   <= rd_pending_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            misaligned_q <= misaligned_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    // Stall drops in DONE so the instruction leaves MEM at the end of that cycle.
    assign bus.stall      = bus.req_valid & (state != DONE);
    assign bus.req_ready  = (state == IDLE);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.misaligned = misaligned_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_mem_byte_sequencer.sv
// tb/tb_mem_byte_sequencer.sv - Directed self-checking bench for mem_byte_sequencer
`timescale 1ns/1ps
module tb_mem_byte_sequencer;
    logic Clk = 1'b0;
    logic R;
    always #5 Clk = ~Clk;

    mem_byte_sequencer_if bus();
    mem_byte_sequencer dut (.Clk(Clk), .R(R), .bus(bus));

    // Synchronous byte memory, 16 bytes aliased by addr[3:0].
    logic [7:0] mem [0:15] = '{default: 8'h00};
    logic [7:0] rd_q = 8'h00;
    assign bus.mem_rdata = rd_q;
    always @(posedge Clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
            else            rd_q <= mem[bus.mem_addr[3:0]];
        end
    end

    int tests = 0;
    int fails = 0;

    int          lat, stall_cnt, n_en;
    logic [31:0] obs_rdata;
    logic        obs_mis, obs_post_valid, obs_post_ready;
    logic [31:0] cyc_addr [4];
    logic        cyc_we   [4];
    logic [7:0]  cyc_wd   [4];

    task automatic run_req(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] size, input logic se);
        bit done;
        @(negedge Clk);
        bus.req_valid = 1'b1; bus.req_rw = rw; bus.req_addr = addr;
        bus.req_wdata = wd; bus.req_size = size; bus.req_se = se;
        #1;
        stall_cnt = bus.stall ? 1 : 0;
        lat = 0; n_en = 0; done = 0; obs_rdata = 32'hDEADBEEF; obs_mis = 1'bx;
        for (int c = 1; c <= 12 && !done; c++) begin
            @(negedge Clk);
            if (bus.stall) stall_cnt++;
            if (bus.mem_en) begin
                if (n_en < 4) begin
                    cyc_addr[n_en] = bus.mem_addr; cyc_we[n_en] = bus.mem_we; cyc_wd[n_en] = bus.mem_wdata;
                end
                n_en++;
            end
            if (bus.rsp_valid) begin
                lat = c; obs_rdata = bus.rsp_rdata; obs_mis = bus.misaligned; done = 1;
            end
        end
        bus.req_valid = 1'b0;
        @(negedge Clk);
        obs_post_valid = bus.rsp_valid;
        obs_post_ready = bus.req_ready;
    endtask

    task automatic test_reset;
        R = 1'b1;
        bus.req_valid = 1'b1; bus.req_rw = 1'b0; bus.req_addr = 32'd8;
        bus.req_wdata = 32'd0; bus.req_size = 2'b10; bus.req_se = 1'b0;
        repeat (2) @(negedge Clk);
        tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready); end
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL reset_stall_valid1: got %b expected 1", bus.stall); end
        tests++; if (bus.rsp_valid !== 1'b0 || bus.misaligned !== 1'b0 || bus.rsp_rdata !== 32'd0) begin
            fails++; $display("FAIL reset_rsp: got valid=%b mis=%b rdata=%h expected 0 0 0", bus.rsp_valid, bus.misaligned, bus.rsp_rdata); end
        tests++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 8'd0) begin
            fails++; $display("FAIL reset_mem: got en=%b we=%b addr=%h wd=%h expected all 0", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        bus.req_valid = 1'b0;
        #1;
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL reset_stall_valid0: got %b expected 0", bus.stall); end
        @(negedge Clk);
        R = 1'b0;
    endtask

    task automatic test_store;
        logic [7:0]  exp_b [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_req(1'b1, 32'd4, 32'hA1B2C3D4, 2'b10, 1'b0);
        tests++; if (lat !== 5) begin fails++; $display("FAIL store_word_latency: got %0d expected 5", lat); end
        tests++; if (stall_cnt !== 5) begin fails++; $display("FAIL store_word_stall: got %0d expected 5", stall_cnt); end
        tests++; if (obs_rdata !== 32'd0 || obs_mis !== 1'b0) begin
            fails++; $display("FAIL store_word_rsp: got rdata=%h mis=%b expected 0 0", obs_rdata, obs_mis); end
        tests++; if (n_en !== 4) begin fails++; $display("FAIL store_word_cycles: got %0d expected 4", n_en); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (cyc_addr[i] !== 32'(4 + i) || cyc_we[i] !== 1'b1 || cyc_wd[i] !== exp_b[i]) begin
                fails++; $display("FAIL store_word_byte%0d: got %h@%h we=%b expected %h@%h we=1", i, cyc_wd[i], cyc_addr[i], cyc_we[i], exp_b[i], 4 + i);
            end
        end
        run_req(1'b1, 32'd2, 32'h0000BEEF, 2'b01, 1'b0);
        tests++; if (lat !== 3 || n_en !== 2) begin fails++; $display("FAIL store_half_timing: got lat=%0d cycles=%0d expected 3 2", lat, n_en); end
        tests++; if (cyc_addr[0] !== 32'd2 || cyc_wd[0] !== 8'hBE || cyc_addr[1] !== 32'd3 || cyc_wd[1] !== 8'hEF) begin
            fails++; $display("FAIL store_half_bytes: got %h@%h %h@%h expected BE@2 EF@3", cyc_wd[0], cyc_addr[0], cyc_wd[1], cyc_addr[1]); end
    endtask

    task automatic test_word_load;
        run_req(1'b1, 32'd8, 32'h801234F6, 2'b10, 1'b0);
        run_req(1'b0, 32'd8, 32'd0, 2'b10, 1'b0);
        tests++; if (lat !== 6) begin fails++; $display("FAIL load_word_latency: got %0d expected 6", lat); end
        tests++; if (stall_cnt !== 6) begin fails++; $display("FAIL load_word_stall: got %0d expected 6", stall_cnt); end
        tests++; if (obs_rdata !== 32'h801234F6) begin fails++; $display("FAIL load_word_data: got %h expected 801234f6", obs_rdata); end
        tests++; if (n_en !== 4) begin fails++; $display("FAIL load_word_cycles: got %0d expected 4", n_en); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (cyc_addr[i] !== 32'(8 + i) || cyc_we[i] !== 1'b0) begin
                fails++; $display("FAIL load_word_addr%0d: got %h we=%b expected %h we=0", i, cyc_addr[i], cyc_we[i], 8 + i);
            end
        end
        tests++; if (obs_post_valid !== 1'b0 || obs_post_ready !== 1'b1) begin
            fails++; $display("FAIL load_word_after: got valid=%b ready=%b expected 0 1", obs_post_valid, obs_post_ready); end
    endtask

    task automatic test_byte_half_load;
        run_req(1'b0, 32'd8, 32'd0, 2'b00, 1'b1);
        tests++; if (lat !== 3 || obs_rdata !== 32'hFFFFFF80) begin
            fails++; $display("FAIL load_byte_se1: got lat=%0d data=%h expected 3 ffffff80", lat, obs_rdata); end
        run_req(1'b0, 32'd8, 32'd0, 2'b00, 1'b0);
        tests++; if (lat !== 3 || obs_rdata !== 32'h00000080) begin
            fails++; $display("FAIL load_byte_se0: got lat=%0d data=%h expected 3 00000080", lat, obs_rdata); end
        run_req(1'b0, 32'd10, 32'd0, 2'b01, 1'b1);
        tests++; if (lat !== 4 || obs_rdata !== 32'h000034F6) begin
            fails++; $display("FAIL load_half_se1: got lat=%0d data=%h expected 4 000034f6", lat, obs_rdata); end
        run_req(1'b0, 32'd8, 32'd0, 2'b01, 1'b1);
        tests++; if (obs_rdata !== 32'hFFFF8012) begin
            fails++; $display("FAIL load_half_neg: got %h expected ffff8012", obs_rdata); end
    endtask

    task automatic test_misaligned;
        logic [31:0] addrs [3] = '{32'd6, 32'd3, 32'd0};
        logic [1:0]  sizes [3] = '{2'b10, 2'b01, 2'b11};
        for (int i = 0; i < 3; i++) begin
            run_req(1'b0, addrs[i], 32'hFFFFFFFF, sizes[i], 1'b1);
            tests++;
            if (lat !== 1 || obs_mis !== 1'b1 || obs_rdata !== 32'd0 || n_en !== 0 || stall_cnt !== 1) begin
                fails++; $display("FAIL misaligned_%0d: got lat=%0d mis=%b data=%h cycles=%0d stall=%0d expected 1 1 0 0 1",
                                  i, lat, obs_mis, obs_rdata, n_en, stall_cnt);
            end
        end
        tests++; if (obs_post_valid !== 1'b0) begin fails++; $display("FAIL misaligned_pulse: got %b expected 0", obs_post_valid); end
    endtask

    task automatic test_reset_midop;
        bit seen;
        run_req(1'b1, 32'd4, 32'h11223344, 2'b10, 1'b0);
        @(negedge Clk);
        bus.req_valid = 1'b1; bus.req_rw = 1'b1; bus.req_addr = 32'd4;
        bus.req_wdata = 32'hA1B2C3D4; bus.req_size = 2'b10; bus.req_se = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        tests++; if (bus.mem_addr !== 32'd5 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 8'hB2) begin
            fails++; $display("FAIL midop_second_cycle: got %h@%h we=%b expected b2@5 we=1", bus.mem_wdata, bus.mem_addr, bus.mem_we); end
        @(posedge Clk);
        #1 R = 1'b1;
        #1;
        tests++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin
            fails++; $display("FAIL midop_async_drop: got en=%b we=%b expected 0 0", bus.mem_en, bus.mem_we); end
        bus.req_valid = 1'b0;
        seen = 0;
        repeat (2) begin @(negedge Clk); if (bus.mem_en || bus.rsp_valid) seen = 1; end
        R = 1'b0;
        repeat (3) begin @(negedge Clk); if (bus.mem_en || bus.rsp_valid) seen = 1; end
        tests++; if (seen !== 1'b0 || bus.req_ready !== 1'b1) begin
            fails++; $display("FAIL midop_quiet: got activity=%b ready=%b expected 0 1", seen, bus.req_ready); end
        run_req(1'b0, 32'd5, 32'd0, 2'b00, 1'b0);
        tests++; if (obs_rdata !== 32'h000000B2) begin fails++; $display("FAIL midop_byte5: got %h expected 000000b2", obs_rdata); end
        run_req(1'b0, 32'd4, 32'd0, 2'b00, 1'b0);
        tests++; if (obs_rdata !== 32'h000000A1) begin fails++; $display("FAIL midop_byte4: got %h expected 000000a1", obs_rdata); end
        run_req(1'b0, 32'd6, 32'd0, 2'b00, 1'b0);
        tests++; if (obs_rdata !== 32'h00000033) begin fails++; $display("FAIL midop_byte6_untouched: got %h expected 00000033", obs_rdata); end
    endtask

    task automatic test_back_to_back;
        int c1, c2, en_cyc;
        logic [31:0] d1, en_addr;
        logic [7:0]  en_wd;
        logic        en_we, ready4, stall4;
        c1 = 0; c2 = 0; en_cyc = 0; d1 = 32'hx; en_addr = 32'hx; en_wd = 8'hx; en_we = 1'bx; ready4 = 1'bx; stall4 = 1'bx;
        @(negedge Clk);
        bus.req_valid = 1'b1; bus.req_rw = 1'b0; bus.req_addr = 32'd8;
        bus.req_wdata = 32'd0; bus.req_size = 2'b00; bus.req_se = 1'b0;
        for (int c = 1; c <= 12 && c2 == 0; c++) begin
            @(negedge Clk);
            if (c == 4) begin ready4 = bus.req_ready; stall4 = bus.stall; end
            if (bus.mem_en && c1 != 0) begin en_cyc = c; en_addr = bus.mem_addr; en_wd = bus.mem_wdata; en_we = bus.mem_we; end
            if (bus.rsp_valid) begin
                if (c1 == 0) begin
                    c1 = c; d1 = bus.rsp_rdata;
                    bus.req_rw = 1'b1; bus.req_addr = 32'd0; bus.req_wdata = 32'h00000077;
                end else begin
                    c2 = c; bus.req_valid = 1'b0;
                end
            end
        end
        bus.req_valid = 1'b0;
        tests++; if (c1 !== 3 || d1 !== 32'h00000080) begin fails++; $display("FAIL b2b_first: got cycle=%0d data=%h expected 3 00000080", c1, d1); end
        tests++; if (ready4 !== 1'b1 || stall4 !== 1'b1) begin fails++; $display("FAIL b2b_idle_gap: got ready=%b stall=%b expected 1 1", ready4, stall4); end
        tests++; if (en_cyc !== 5 || en_addr !== 32'd0 || en_wd !== 8'h77 || en_we !== 1'b1) begin
            fails++; $display("FAIL b2b_store_cycle: got cycle=%0d %h@%h we=%b expected 5 77@0 1", en_cyc, en_wd, en_addr, en_we); end
        tests++; if (c2 !== 6) begin fails++; $display("FAIL b2b_second: got cycle=%0d expected 6", c2); end
    endtask

    task automatic test_addr_wrap;
        run_req(1'b1, 32'hFFFFFFFF, 32'h0000005A, 2'b00, 1'b0);
        tests++; if (lat !== 2 || n_en !== 1 || cyc_addr[0] !== 32'hFFFFFFFF || cyc_wd[0] !== 8'h5A) begin
            fails++; $display("FAIL wrap_store: got lat=%0d cycles=%0d %h@%h expected 2 1 5a@ffffffff", lat, n_en, cyc_wd[0], cyc_addr[0]); end
        run_req(1'b0, 32'hFFFFFFFF, 32'd0, 2'b00, 1'b1);
        tests++; if (lat !== 3 || n_en !== 1 || cyc_addr[0] !== 32'hFFFFFFFF || obs_rdata !== 32'h0000005A) begin
            fails++; $display("FAIL wrap_load: got lat=%0d cycles=%0d addr=%h data=%h expected 3 1 ffffffff 0000005a", lat, n_en, cyc_addr[0], obs_rdata); end
    endtask

    initial begin
        R = 1'b1;
        bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0; bus.req_size = 2'b00; bus.req_se = 1'b0;
        test_reset;
        test_store;
        test_word_load;
        test_byte_half_load;
        test_misaligned;
        test_reset_midop;
        test_back_to_back;
        test_addr_wrap;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_byte_sequencer.md
# mem_byte_sequencer

MEM-stage access sequencer between the EX/MEM pipeline register and the byte-wide data memory. Accepts one load or store per request (byte, halfword or word, big-endian), breaks it into consecutive single-byte memory cycles, and assembles and extends load data. While the access is in flight it drives a stall to the hazard logic. It replaces the single-cycle data-memory path, so the pipeline works with a synchronous 8-bit memory array.

## Interface
- No parameters. Data width is 32, memory width is 8, and addresses are 32-bit byte addresses.
- Clk  in  1  pipeline clock; all state changes on the rising edge.
- R  in  1  reset, asynchronous, active-high.
- req_valid  in  1  MEM_DataMem_enable of the instruction in MEM.
- req_rw  in  1  0 = load, 1 = store (MEM_Read_Write).
- req_addr  in  32  byte address (MEM_ALU_Out).
- req_wdata  in  32  store data (MEM_DataIn).
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal (MEM_size_dm).
- req_se  in  1  load sign-extend (MEM_SE_dm).
- req_ready  out  1  high only in IDLE.
- stall  out  1  freeze PC/nPC, IF/ID, ID/EX and EX/MEM.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- misaligned  out  1  qualifies rsp_valid; the access was rejected.
- mem_en  out  1  byte-memory cycle enable.
- mem_we  out  1  byte-memory write enable.
- mem_addr  out  32  byte-memory address.
- mem_wdata  out  8  byte-memory write data.
- mem_rdata  in  8  byte-memory read data, valid the cycle after a read cycle is issued.

## Operation
- Byte count N is 1, 2 or 4 for size 00, 01 or 10.
- States:
  - IDLE → XFER on accept, which is req_valid at an edge while in IDLE.
  - XFER → XFER while count < N-1.
  - XFER → DONE (store) or CAPT (load) at count = N-1.
  - CAPT → DONE.
  - DONE → IDLE.
- Misaligned requests go IDLE → DONE directly with no memory cycle. A request is misaligned when:
  - size 01 and addr[0] = 1,
  - size 10 and addr[1:0] ≠ 00,
  - or size 11.
- Accept latches addr, wdata, size, se and rw, and clears count and the accumulator.
- XFER issues one byte per cycle:
  - mem_en = 1, mem_we = rw, mem_addr = base + count (32-bit modulo add).
  - mem_wdata is the store byte, most significant first. Word: [31:24], [23:16], [15:8], [7:0]. Half: [15:8], [7:0]. Byte: [7:0].
- Loads: at each edge after a read cycle, the accumulator becomes {acc[23:0], mem_rdata}. The last byte is captured in CAPT.
- DONE drives rsp_valid = 1 and misaligned = error flag. For loads rsp_rdata is:
  - byte: {24{se & acc[7]}, acc[7:0]}
  - half: {16{se & acc[15]}, acc[15:0]}
  - word: acc
- stall = req_valid & (state ≠ DONE). It is combinational so the instruction advances out of MEM at the end of DONE.
- req_valid dropping mid-transaction is ignored; the latched transaction completes.
- Outside XFER: mem_en = 0, mem_we = 0, and mem_addr/mem_wdata hold 0.

## Timing
- Reset, immediate and asynchronous: state IDLE, count 0, accumulator 0.
  - rsp_valid, rsp_rdata and misaligned = 0.
  - mem_en, mem_we, mem_addr and mem_wdata = 0.
  - req_ready = 1; stall = req_valid.
- Reset mid-transaction aborts it: no rsp_valid, no further memory cycles, and mem_we falls with R.
- Cycles from accept edge to the rsp_valid cycle:
  - store: N + 1
  - load: N + 2
  - misaligned: 1
- Total stall cycles equal that latency (stall high from the accept cycle, low in DONE).
- Back-to-back: a new request is accepted at the edge that ends the IDLE cycle following DONE. The minimum spacing between accepts is latency + 1 cycles.
- Memory outputs and rsp_* derive only from flops, so they are glitch-free.

## Test plan
- Word load, se = 0:
  - Stimulus: Mem[8..11] = 80, 12, 34, F6; addr 8, size 10.
  - Response: mem_addr 8, 9, 10, 11 in consecutive cycles; rsp_valid 6 cycles after accept; rsp_rdata 0x801234F6; stall high for exactly 6 cycles.
- Byte and half loads:
  - addr 8, size 00, se 1 → 0xFFFFFF80 after 3 cycles.
  - Same with se 0 → 0x00000080.
  - addr 10, size 01, se 1 → 0x000034F6.
- Stores:
  - Word store 0xA1B2C3D4 at addr 4 → mem_we cycles write A1@4, B2@5, C3@6, D4@7; rsp_valid at cycle 5; rsp_rdata 0.
  - Half store 0x0000BEEF at addr 2 → BE@2, EF@3.
- Misaligned:
  - Word at addr 6 → no mem_en; rsp_valid and misaligned high 1 cycle after accept.
  - Half at addr 3 and size 11 at addr 0 → same response.
- Reset mid-op: assert R during the 2nd XFER cycle of a word store.
  - Required: mem_en/mem_we drop immediately, only bytes @4 and @5 written, no rsp_valid, req_ready = 1 after release.
  - A subsequent byte load at addr 5 → 0x000000B2.
- Back-to-back load then store with req_valid held:
  - Second accept lands on the IDLE cycle after the first DONE.
  - Address wrap: byte load at 0xFFFFFFFF → mem_addr 0xFFFFFFFF, no overflow artifacts.
